// File: rtl/add_seq_pkg.sv
// ---------------------------------------------------------------------------
// add_seq_pkg
// Shared types and constants for the byte-serial adder controller.
//   state_t : controller FSM states (IDLE / BUSY / DONE)
//   BYTE_W  : width of the time-shared adder slice
// ---------------------------------------------------------------------------
package add_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add8_slice.sv
// ---------------------------------------------------------------------------
// add8_slice
// Combinational byte adder used once per cycle by add_seq_ctrl.
// Ports:
//   a8, b8 : operand bytes
//   ci     : carry into bit 0
//   s8     : sum byte
//   co     : carry out of bit 7
//   c7     : carry into bit 7 (co ^ c7 gives signed overflow on the top byte)
// ---------------------------------------------------------------------------
module add8_slice
    import add_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a8,
    input  logic [BYTE_W-1:0] b8,
    input  logic              ci,
    output logic [BYTE_W-1:0] s8,
    output logic              co,
    output logic              c7
);

    // Split the add at the MSB so the carry into bit 7 is visible.
    logic [BYTE_W-1:0] low_sum;
    logic [1:0]        top_sum;

    assign low_sum = {1'b0, a8[BYTE_W-2:0]} + {1'b0, b8[BYTE_W-2:0]}
                   + {{(BYTE_W-1){1'b0}}, ci};
    assign c7      = low_sum[BYTE_W-1];
    assign top_sum = {1'b0, a8[BYTE_W-1]} + {1'b0, b8[BYTE_W-1]} + {1'b0, c7};

    assign s8 = {top_sum[0], low_sum[BYTE_W-2:0]};
    assign co = top_sum[1];

endmodule

// File: rtl/add_seq_ctrl.sv
// ---------------------------------------------------------------------------
// add_seq_ctrl
// Byte-serial adder: one 8-bit slice processes one byte per cycle, LSB first.
// A request is accepted in IDLE, takes exactly NBYTES BUSY cycles, then the
// result is held in DONE until consumed. Build option ADD_SEQ_SUB_EN adds the
// op input (1 = subtract: a + ~b + 1, Cout=1 means no borrow).
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : request handshake (a, b, Cin, op)
//   out_valid/out_ready: result handshake (Sum, Cout, Ovf)
// ---------------------------------------------------------------------------
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*NBYTES-1:0]      a,
    input  logic [8*NBYTES-1:0]      b,
    input  logic                     Cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                     op,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*NBYTES-1:0]      Sum,
    output logic                     Cout,
    output logic                     Ovf
);

    localparam int                IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        idx_reg;
    logic                    carry_reg;
    logic [8*NBYTES-1:0]     a_reg, b_reg;
    logic                    cout_reg, ovf_reg;

    logic [BYTE_W-1:0]       slice_a, slice_b, slice_s;
    logic                    slice_co, slice_c7;
    logic                    sub_sel;

`ifdef ADD_SEQ_SUB_EN
    assign sub_sel = op;
`else
    assign sub_sel = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (idx_reg == LAST_IDX) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                // Always return through IDLE, so a result consume and a new
                // accept can never share a cycle.
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- byte select for the shared slice ----------------
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                slice_a = a_reg[i*BYTE_W +: BYTE_W];
                slice_b = b_reg[i*BYTE_W +: BYTE_W];
            end
        end
    end

    add8_slice u_slice (
        .a8 (slice_a),
        .b8 (slice_b),
        .ci (carry_reg),
        .s8 (slice_s),
        .co (slice_co),
        .c7 (slice_c7)
    );

    // ---------------- operand capture, carry chain, flags ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        // Subtract is a + ~b + 1; Cin is ignored then.
                        b_reg     <= sub_sel ? ~b : b;
                        carry_reg <= sub_sel ? 1'b1 : Cin;
                        idx_reg   <= '0;
                    end
                end
                BUSY: begin
                    carry_reg <= slice_co;
                    idx_reg   <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        cout_reg <= slice_co;
                        ovf_reg  <= slice_co ^ slice_c7;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- per-byte result registers ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_sum
            logic [BYTE_W-1:0] byte_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    byte_reg <= '0;
                else if (state_reg == BUSY && idx_reg == IDX_W'(gi))
                    byte_reg <= slice_s;
            end
            assign Sum[gi*BYTE_W +: BYTE_W] = byte_reg;
        end
    endgenerate

    assign Cout = cout_reg;
    assign Ovf  = ovf_reg;

endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 4: operand width in bytes (legal 1..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port a  input  8*NBYTES  operand A.
REQ-007 SHALL have port b  input  8*NBYTES  operand B.
REQ-008 SHALL have port Cin  input  1  carry-in to byte 0.
REQ-009 SHALL have port op  input  1  0=add, 1=subtract; present only when ADD_SEQ_SUB_EN is defined.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port Sum  output  8*NBYTES  result.
REQ-013 SHALL have port Cout  output  1  carry out of the top byte.
REQ-014 SHALL have port Ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL time-share one 8-bit adder slice, processing one byte per cycle, LSB byte first.
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 In IDLE: in_ready=1; on in_valid&in_ready, register a, b, Cin (and op), clear byte index to 0, go BUSY.
REQ-018 In BUSY, each cycle: Sum byte[idx] <= a[idx]+b[idx]+carry; carry register <= slice carry-out; idx increments.
REQ-019 Carry into byte 0 SHALL be the registered Cin; carry into byte k>0 SHALL be the carry out of byte k-1.
REQ-020 After the byte with idx=NBYTES-1 is processed, go DONE; BUSY lasts exactly NBYTES cycles.
REQ-021 out_valid SHALL assert on the edge that processes the last byte, i.e. NBYTES cycles after the accepting edge.
REQ-022 In DONE: out_valid=1; Sum, Cout, Ovf held stable until out_valid&out_ready, then go IDLE.
REQ-023 Ovf SHALL be (carry into MSB bit) XOR (carry out of MSB bit) of the top byte.
REQ-024 in_ready SHALL be 0 in BUSY and DONE; in_valid and operand changes in those states SHALL be ignored.
REQ-025 No new request SHALL be accepted in the same cycle a result is consumed; IDLE is always entered first.
REQ-026 NBYTES=1: BUSY lasts one cycle; behaviour otherwise identical.

Reset
REQ-027 rst SHALL asynchronously force IDLE, idx=0, carry=0, Sum=0, Cout=0, Ovf=0, out_valid=0, in_ready=1.
REQ-028 rst asserted in BUSY or DONE SHALL discard the in-flight operation with no partial result visible.

Configuration
REQ-029 Macro ADD_SEQ_SUB_EN defined: op port exists; op=1 registers ~b and forces carry into byte 0 to 1 (Cin ignored); Cout=1 means no borrow.
REQ-030 Macro ADD_SEQ_SUB_EN undefined: op port absent; block performs addition only.

Structure
REQ-031 Package add_seq_pkg SHALL hold the FSM state typedef (IDLE/BUSY/DONE) and constant BYTE_W=8.
REQ-032 Sub-module add8_slice SHALL be the combinational 8-bit adder (a8, b8, ci -> s8, co, plus carry into bit 7 for Ovf), instantiated once.

Verification (NBYTES=4)
REQ-033 a=0x000000FF, b=0x00000001, Cin=0 -> Sum=0x00000100, Cout=0, Ovf=0; out_valid exactly 4 cycles after accept.
REQ-034 a=0xFFFFFFFF, b=0x00000000, Cin=1 -> Sum=0x00000000, Cout=1, Ovf=0 (carry ripples through all bytes).
REQ-035 a=0x7FFFFFFF, b=0x00000001, Cin=0 -> Sum=0x80000000, Cout=0, Ovf=1.
REQ-036 out_ready held 0 for 3 cycles in DONE while in_valid=1 with new operands -> Sum/Cout/Ovf unchanged, in_ready=0; after out_ready=1, IDLE next cycle, in_ready=1.
REQ-037 rst pulsed after 2 BUSY cycles -> immediately out_valid=0, Sum=0, in_ready=1; next request a=3,b=4 -> Sum=0x00000007.
REQ-038 ADD_SEQ_SUB_EN defined, op=1, a=5, b=7 -> Sum=0xFFFFFFFE, Cout=0, Ovf=0; op=1, a=0x80000000, b=1 -> Sum=0x7FFFFFFF, Cout=1, Ovf=1.
